// File: rtl/edge_generator.sv
// Rebuilds a level waveform from single-cycle rise/fall/toggle requests.
// The waveform honours minimum high/low widths and has a one-deep pending slot.
module edge_generator #(
  parameter int unsigned MIN_HIGH = 4,
  parameter int unsigned MIN_LOW  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_req,
  input  logic fall_req,
  input  logic tog_req,
  output logic level,
  output logic edge_o,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  // Illegal widths are rejected while elaborating.
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("edge_generator: CNT_W must be 1..32");
  end
  if (MIN_HIGH < 1 || longint'(MIN_HIGH) > (longint'(1) << CNT_W)) begin : g_bad_min_high
    $error("edge_generator: MIN_HIGH must be 1..2**CNT_W");
  end
  if (MIN_LOW < 1 || longint'(MIN_LOW) > (longint'(1) << CNT_W)) begin : g_bad_min_low
    $error("edge_generator: MIN_LOW must be 1..2**CNT_W");
  end

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             edge_q, edge_d;
  logic             drop_q, drop_d;
  logic             busy_q;
  logic             conflict;
  logic             eff_cur;
  logic             eff_post;
  logic             flip;

  // Request decode and next-state selection.
  always_comb begin
    conflict = (rise_req & fall_req) | (rise_req & tog_req) | (fall_req & tog_req);
    // eff_post judges the request against the level after a pending flip.
    eff_cur  = ~conflict & (tog_req | (rise_req & ~level_q) | (fall_req & level_q));
    eff_post = ~conflict & (tog_req | (rise_req & level_q) | (fall_req & ~level_q));

    level_d = level_q;
    cnt_d   = cnt_q - CNT_W'(cnt_q != '0);
    pend_d  = pend_q;
    edge_d  = 1'b0;
    drop_d  = conflict;
    flip    = 1'b0;

    if (cnt_q != '0) begin
      if (eff_cur) begin
        if (!pend_q) pend_d = 1'b1;
        else         drop_d = 1'b1;
      end
    end else if (pend_q) begin
      flip   = 1'b1;
      pend_d = eff_post;
    end else if (eff_cur) begin
      flip = 1'b1;
    end

    if (flip) begin
      level_d = ~level_q;
      edge_d  = 1'b1;
      cnt_d   = level_q ? LOW_LOAD : HIGH_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      edge_q  <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      edge_q  <= edge_d;
      drop_q  <= drop_d;
      busy_q  <= (cnt_d != '0);
    end
  end

  assign level  = level_q;
  assign edge_o = edge_q;
  assign busy   = busy_q;
  assign drop   = drop_q;

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator: one instance with 4-cycle widths, one with 1-cycle widths.
module tb_edge_generator;

  logic clk;
  logic rst_n;
  logic rise_req, fall_req, tog_req;
  logic level, edge_o, busy, drop;
  logic rise1, fall1, tog1;
  logic level1, edge1, busy1, drop1;

  int tests;
  int fails;

  edge_generator #(.MIN_HIGH(4), .MIN_LOW(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rise_req(rise_req), .fall_req(fall_req), .tog_req(tog_req),
    .level(level), .edge_o(edge_o), .busy(busy), .drop(drop)
  );

  edge_generator #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rise_req(rise1), .fall_req(fall1), .tog_req(tog1),
    .level(level1), .edge_o(edge1), .busy(busy1), .drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic l, input logic e,
                            input logic b, input logic d);
    check({tag, ".level"}, 32'(level), 32'(l));
    check({tag, ".edge"},  32'(edge_o), 32'(e));
    check({tag, ".busy"},  32'(busy), 32'(b));
    check({tag, ".drop"},  32'(drop), 32'(d));
  endtask

  // Present a request for one cycle; on return the outputs of the next cycle are visible.
  task automatic cyc(input logic r, input logic f, input logic t);
    rise_req = r;
    fall_req = f;
    tog_req  = t;
    @(posedge clk);
    #1;
    rise_req = 1'b0;
    fall_req = 1'b0;
    tog_req  = 1'b0;
  endtask

  int pulses;
  logic prev_level1;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    rise_req = 1'b0; fall_req = 1'b0; tog_req = 1'b0;
    rise1 = 1'b0; fall1 = 1'b0; tog1 = 1'b0;
    #12;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back toggles with 1-cycle widths.
    pulses = 0;
    prev_level1 = level1;
    for (int i = 0; i < 8; i++) begin
      tog1 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.level", i), 32'(level1), 32'(i % 2 == 0));
      check($sformatf("b2b%0d.edge", i),  32'(edge1), 32'd1);
      check($sformatf("b2b%0d.busy", i),  32'(busy1), 32'd0);
      check($sformatf("b2b%0d.drop", i),  32'(drop1), 32'd0);
      if (level1 !== prev_level1) pulses++;
      prev_level1 = level1;
    end
    tog1 = 1'b0;
    check("b2b.pulses", 32'(pulses), 32'd8);
    @(posedge clk);
    #1;
    check("b2b.after_edge", 32'(edge1), 32'd0);
    check("b2b.after_level", 32'(level1), 32'd0);

    // Minimum-width hold: rise @10, fall @12.
    cyc(1'b1, 1'b0, 1'b0); expect_out("hold11", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold12", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); expect_out("hold13", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold14", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold15", 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold16", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold17", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("hold18", 1'b0, 1'b0, 1'b0, 1'b0);

    // Pending slot full: rise @10, tog @12, tog @13.
    cyc(1'b1, 1'b0, 1'b0); expect_out("pend11", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("pend12", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); expect_out("pend13", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); expect_out("pend14", 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("pend15", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("pend_after%0d.level", i), 32'(level), 32'd0);
      check($sformatf("pend_after%0d.edge", i),  32'(edge_o), 32'd0);
    end
    check("pend_idle.busy", 32'(busy), 32'd0);

    // Conflict while idle at level 0.
    cyc(1'b1, 1'b1, 1'b0); expect_out("conf21", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("conf22", 1'b0, 1'b0, 1'b0, 1'b0);

    // Redundant rise at level 1 once the hold has expired.
    cyc(1'b1, 1'b0, 1'b0); expect_out("redun_up", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("redun_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0); expect_out("redun31", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("redun32", 1'b1, 1'b0, 1'b0, 1'b0);

    // Back to level 0 and idle before the reset test.
    cyc(1'b0, 1'b1, 1'b0); expect_out("down", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    expect_out("down_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-hold with a pending fall and another fall in flight.
    cyc(1'b1, 1'b0, 1'b0); expect_out("rst11", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); expect_out("rst12", 1'b1, 1'b0, 1'b1, 1'b0);
    fall_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    fall_req = 1'b0;
    @(posedge clk);
    #1;
    expect_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      expect_out($sformatf("rst_rel%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound the run in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/edge_generator.md
Name: edge_generator

Overview:
- Converts single-cycle edge requests (rise, fall, toggle) back into a clean level waveform on `level`.
- Enforces a minimum high time and a minimum low time on that level.
- Has a one-deep pending slot for requests that arrive while a minimum width is still running.
- Used to drive strobes and handshake lines whose far end is decoded by the pos/neg/any-edge detectors.

Parameters:
- MIN_HIGH, 4, minimum cycles `level` stays 1 after a rising edge (1..2^CNT_W).
- MIN_LOW, 4, minimum cycles `level` stays 0 after a falling edge (1..2^CNT_W).
- CNT_W, 8, width of the hold counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rise_req  input  1  single-cycle request: drive level to 1.
- fall_req  input  1  single-cycle request: drive level to 0.
- tog_req  input  1  single-cycle request: invert level.
- level  output  1  generated waveform, registered.
- edge_o  output  1  one-cycle pulse in the first cycle a new level is visible.
- busy  output  1  minimum-width hold in progress (hold counter != 0).
- drop  output  1  one-cycle pulse: a request was discarded (conflict or pending slot full).

Behaviour:
- Reset (async, rst_n=0):
  - level=0, edge_o=0, busy=0, drop=0.
  - Hold counter cnt=0; pending slot empty.
  - Effective immediately, including mid-hold.
- Request decode each cycle:
  - More than one of rise_req/fall_req/tog_req high is a conflict: the request is discarded and drop=1 in the next cycle.
  - Otherwise the request is "effective" if it would change the level it is evaluated against. tog_req is always effective. rise_req is effective only against 0; fall_req only against 1.
  - A non-effective request is ignored silently; drop stays 0.
- Edge execution (latency 1 cycle):
  - A request executed in cycle T gives: level inverted at T+1; edge_o=1 at T+1 only.
  - cnt loaded at T+1 with MIN_HIGH-1 (new level 1) or MIN_LOW-1 (new level 0).
- Hold counter:
  - cnt decrements by 1 each cycle while nonzero.
  - busy = (cnt != 0).
  - The cycle with cnt==0 is the earliest cycle in which an edge may execute, so the level is held exactly MIN_x cycles minimum.
- Cycle with cnt != 0:
  - An effective request, evaluated against the current level, is stored in the pending slot if the slot is empty.
  - If the slot is already full, the request is discarded and drop=1 next cycle.
  - The stored request is always an inversion.
- Cycle with cnt == 0 and pending slot full:
  - The pending edge executes and the slot clears.
  - A fresh request in the same cycle is evaluated against the post-edge level. If effective, it is stored as the new pending request; otherwise it is ignored.
- Cycle with cnt == 0 and pending slot empty: an effective fresh request executes directly.
- MIN_x=1: the counter loads 0, so busy never asserts for that level and a request every cycle toggles level every cycle.
- Outputs are registered; no combinational path from request inputs to any output.
- Counter arithmetic is unsigned CNT_W bits. Parameters outside 1..2^CNT_W are illegal; an elaboration-time check is required.

Test Plan:
- Reset mid-hold:
  - Stimulus: MIN_HIGH=4; rise_req @10; fall_req @12; rst_n=0 asynchronously @12.5.
  - Required: level=0, busy=0, pending cleared at once; no edge after release; drop never 1.
- Min-width hold:
  - Stimulus: MIN_HIGH=4; rise_req @10; fall_req @12.
  - Required: level=1 on cycles 11..14, edge_o @11 and @15, busy @11..13, level=0 @15, busy @15..17 (MIN_LOW=4).
- Pending full:
  - Stimulus: MIN_HIGH=4; rise_req @10; tog_req @12; tog_req @13.
  - Required: first toggle pending, second discarded with drop=1 @14; level=0 @15; level stays 0 thereafter.
- Conflict:
  - Stimulus: rise_req=fall_req=1 @20 with level 0, idle.
  - Required: level stays 0, edge_o=0, drop=1 @21 only.
- Redundant request:
  - Stimulus: level=1, cnt=0; rise_req @30.
  - Required: no level change, edge_o=0, drop=0.
- Back-to-back toggles:
  - Stimulus: MIN_HIGH=MIN_LOW=1; tog_req on cycles 40..47.
  - Required: level toggles @41..48, edge_o=1 @41..48, busy=0 and drop=0 throughout; a downstream any-edge detector sees 8 pulses.
